// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand delivery.
// Resolves RAW hazards by forwarding and inserts load-use bubbles.
module ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [5:0]    id_alufun,
    input  logic          id_sign,
    input  logic          id_asel_shamt,
    input  logic          id_bsel_imm,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          flush,
    input  logic          freeze,
    input  logic          mem_regwrite,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_regwrite,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic          hazard_stall,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [5:0]    alu_fun,
    output logic          alu_sign,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [RW-1:0] ex_rd,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic [DW-1:0] ex_store_data
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
        logic [5:0]    alufun;
        logic          sign;
        logic          asel;
        logic          bsel;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
    } id_ex_t;

    id_ex_t ex_q;
    id_ex_t ex_d;
    id_ex_t cap;

    logic          wb_hit_rs;
    logic          wb_hit_rt;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // WB writes in the same cycle ID reads the register file.
    assign wb_hit_rs = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs);
    assign wb_hit_rt = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rt);

    always_comb begin
        cap          = '0;
        cap.valid    = 1'b1;
        cap.pc       = id_pc;
        cap.rs       = id_rs;
        cap.rt       = id_rt;
        cap.rd       = id_rd;
        cap.rs_data  = wb_hit_rs ? wb_data : id_rs_data;
        cap.rt_data  = wb_hit_rt ? wb_data : id_rt_data;
        cap.imm      = id_imm;
        cap.shamt    = id_shamt;
        cap.alufun   = id_alufun;
        cap.sign     = id_sign;
        cap.asel     = id_asel_shamt;
        cap.bsel     = id_bsel_imm;
        cap.regwrite = id_regwrite;
        cap.memread  = id_memread;
        cap.memwrite = id_memwrite;
    end

    assign hazard_stall = ex_q.valid && ex_q.memread && (ex_q.rd != '0)
                       && id_valid
                       && ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));

    always_comb begin
        ex_d = ex_q;
        if (freeze) begin
            ex_d = ex_q;
        end else if (flush || hazard_stall || !id_valid) begin
            ex_d = '0;
        end else begin
            ex_d = cap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM has priority; register 0 never forwards.
    function automatic logic [DW-1:0] fwd(
        input logic [RW-1:0] idx,
        input logic [DW-1:0] reg_data
    );
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == idx)) begin
            return mem_result;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == idx)) begin
            return wb_data;
        end else begin
            return reg_data;
        end
    endfunction

    assign fwd_rs = fwd(ex_q.rs, ex_q.rs_data);
    assign fwd_rt = fwd(ex_q.rt, ex_q.rt_data);

    assign alu_a         = ex_q.asel ? {{(DW-5){1'b0}}, ex_q.shamt} : fwd_rs;
    assign alu_b         = ex_q.bsel ? ex_q.imm : fwd_rt;
    assign alu_fun       = ex_q.alufun;
    assign alu_sign      = ex_q.sign;
    assign ex_store_data = fwd_rt;

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_rd       = ex_q.rd;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage.
// Each step drives inputs after an edge and checks with immediate asserts.
module tb_ex_operand_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]    id_shamt;
    logic [5:0]    id_alufun;
    logic          id_sign, id_asel_shamt, id_bsel_imm;
    logic          id_regwrite, id_memread, id_memwrite;
    logic          flush, freeze;
    logic          mem_regwrite;
    logic [RW-1:0] mem_rd;
    logic [DW-1:0] mem_result;
    logic          wb_regwrite;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          hazard_stall;
    logic [DW-1:0] alu_a, alu_b;
    logic [5:0]    alu_fun;
    logic          alu_sign;
    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [RW-1:0] ex_rd;
    logic          ex_regwrite, ex_memread, ex_memwrite;
    logic [DW-1:0] ex_store_data;

    int checks   = 0;
    int failures = 0;

    ex_operand_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alufun(id_alufun), .id_sign(id_sign),
        .id_asel_shamt(id_asel_shamt), .id_bsel_imm(id_bsel_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite),
        .flush(flush), .freeze(freeze),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .hazard_stall(hazard_stall),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_fun(alu_fun), .alu_sign(alu_sign),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_pc = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_shamt = '0; id_alufun = '0; id_sign = 0;
        id_asel_shamt = 0; id_bsel_imm = 0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0;
        flush = 0; freeze = 0;
        mem_regwrite = 0; mem_rd = '0; mem_result = '0;
        wb_regwrite = 0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic id_instr(input logic [31:0] pc, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid = 1; id_pc = pc;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd;
        id_asel_shamt = 0; id_bsel_imm = 0;
        id_regwrite = 1; id_memread = 0; id_memwrite = 0;
        id_alufun = 6'b000000; id_sign = 0;
    endtask

    initial begin
        idle();
        #2;
        // reset with live, random inputs
        reset = 1;
        id_valid = 1; id_pc = $urandom; id_rs = 5'd3; id_rt = 5'd4;
        id_rd = 5'd6; id_rs_data = $urandom; id_rt_data = $urandom;
        id_alufun = 6'b101010; id_regwrite = 1; id_memread = 1;
        mem_regwrite = 1; mem_rd = 5'd3; mem_result = $urandom;
        tick();
        tick();
        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_fun", {26'b0, alu_fun}, 32'd0);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_b", alu_b, 32'd0);
        chk("rst_stall", {31'b0, hazard_stall}, 32'd0);
        reset = 0;
        idle();

        // forwarding priority
        id_instr(32'h10, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22);
        tick();
        idle();
        mem_regwrite = 1; mem_rd = 5'd3; mem_result = 32'h100;
        wb_regwrite = 1; wb_rd = 5'd3; wb_data = 32'h200;
        #1;
        chk("fwd_valid", {31'b0, ex_valid}, 32'd1);
        chk("fwd_mem_a", alu_a, 32'h100);
        chk("fwd_mem_b", alu_b, 32'h22);
        mem_rd = 5'd0;
        #1;
        chk("fwd_wb_a", alu_a, 32'h200);
        wb_rd = 5'd0;
        #1;
        chk("fwd_zero_a", alu_a, 32'h11);
        mem_rd = 5'd4;
        #1;
        chk("fwd_rt_b", alu_b, 32'h100);
        chk("fwd_rt_st", ex_store_data, 32'h100);
        idle();
        tick();

        // load-use stall
        id_instr(32'h20, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0);
        id_memread = 1;
        tick();
        id_instr(32'h24, 5'd5, 5'd6, 5'd8, 32'h77, 32'h0);
        #1;
        chk("lu_stall", {31'b0, hazard_stall}, 32'd1);
        tick();
        chk("lu_bub_v", {31'b0, ex_valid}, 32'd0);
        chk("lu_bub_rw", {31'b0, ex_regwrite}, 32'd0);
        chk("lu_stall0", {31'b0, hazard_stall}, 32'd0);
        tick();
        idle();
        mem_regwrite = 1; mem_rd = 5'd5; mem_result = 32'hABCD;
        #1;
        chk("lu_add_v", {31'b0, ex_valid}, 32'd1);
        chk("lu_add_rd", {27'b0, ex_rd}, 32'd8);
        chk("lu_add_a", alu_a, 32'hABCD);
        idle();

        // WB capture bypass
        id_instr(32'h40, 5'd7, 5'd0, 5'd9, 32'h1, 32'h0);
        wb_regwrite = 1; wb_rd = 5'd7; wb_data = 32'hDEAD;
        tick();
        idle();
        #1;
        chk("cap_a", alu_a, 32'hDEAD);

        // freeze holds despite changing ID
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            id_instr(32'h100 + i, 5'd2, 5'd3, 5'd4, 32'h5, 32'h6);
            tick();
            chk("frz_pc", ex_pc, 32'h40);
            chk("frz_a", alu_a, 32'hDEAD);
        end
        flush = 1;
        tick();
        chk("frz_flush_v", {31'b0, ex_valid}, 32'd1);
        chk("frz_flush_pc", ex_pc, 32'h40);
        idle();

        // stall visible in freeze, flush wins over stall
        id_instr(32'h50, 5'd1, 5'd0, 5'd9, 32'h0, 32'h0);
        id_memread = 1;
        tick();
        id_instr(32'h54, 5'd9, 5'd2, 5'd10, 32'h0, 32'h0);
        freeze = 1;
        #1;
        chk("frz_stall", {31'b0, hazard_stall}, 32'd1);
        tick();
        chk("frz_lw_mr", {31'b0, ex_memread}, 32'd1);
        freeze = 0; flush = 1;
        #1;
        chk("fl_stall", {31'b0, hazard_stall}, 32'd1);
        tick();
        chk("fl_bub_v", {31'b0, ex_valid}, 32'd0);
        chk("fl_bub_mr", {31'b0, ex_memread}, 32'd0);
        chk("fl_bub_pc", ex_pc, 32'd0);
        idle();

        // operand select
        id_instr(32'h60, 5'd2, 5'd4, 5'd11, 32'h33, 32'h55);
        id_asel_shamt = 1; id_shamt = 5'd4;
        id_bsel_imm = 1; id_imm = 32'hFFFFFFF0;
        id_alufun = 6'b100011; id_sign = 1;
        tick();
        idle();
        #1;
        chk("sel_a", alu_a, 32'd4);
        chk("sel_b", alu_b, 32'hFFFFFFF0);
        chk("sel_fun", {26'b0, alu_fun}, 32'h23);
        chk("sel_sign", {31'b0, alu_sign}, 32'd1);
        chk("sel_st", ex_store_data, 32'h55);
        mem_regwrite = 1; mem_rd = 5'd4; mem_result = 32'h999;
        #1;
        chk("sel_st_fwd", ex_store_data, 32'h999);
        chk("sel_b_imm", alu_b, 32'hFFFFFFF0);
        idle();

        // id_valid=0 loads a bubble
        tick();
        chk("inv_v", {31'b0, ex_valid}, 32'd0);
        chk("inv_fun", {26'b0, alu_fun}, 32'd0);

        // reset overrides freeze
        id_instr(32'h70, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2);
        tick();
        chk("pre_rst_v", {31'b0, ex_valid}, 32'd1);
        freeze = 1; reset = 1;
        tick();
        chk("rst_frz_v", {31'b0, ex_valid}, 32'd0);
        chk("rst_frz_pc", ex_pc, 32'd0);
        reset = 0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
